// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, the canonical NOP and immediate-format classification.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;
    localparam logic [6:0] OP_LUI    = 7'b011_0111;
    localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OP_IMM    = 7'b001_0011;
    localparam logic [6:0] OP_REG    = 7'b011_0011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: return IMM_I;
            OP_STORE:                 return IMM_S;
            OP_BRANCH:                return IMM_B;
            OP_LUI, OP_AUIPC:         return IMM_U;
            OP_JAL:                   return IMM_J;
            default:                  return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 32-entry register file: two combinational read ports, one write port, x0 hardwired to zero.
// Optional write-through on reads selected by REGFILE_BYPASS_EN.
module register_file #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (we && rd_addr != 5'd0) begin
            regs[rd_addr] <= wd;
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
        rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (we && rd_addr != 5'd0 && rd_addr == rs1_addr) rs1_data = wd;
        if (we && rd_addr != 5'd0 && rd_addr == rs2_addr) rs2_data = wd;
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, register file, immediate generation, load-use stall, ID/EX register.
// Register-file write-through is enabled by defining REGFILE_BYPASS_EN.
module decode_stage #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instr_in,
    input  logic            PCSrc,
    input  logic            reg_write_wb,
    input  logic [4:0]      rd_wb,
    input  logic [XLEN-1:0] wd_wb,
    input  logic            idex_mem_read,
    input  logic [4:0]      idex_rd_in,
    output logic            PCWrite,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_rs1_data,
    output logic [XLEN-1:0] id_rs2_data,
    output logic [XLEN-1:0] id_imm,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic            id_funct7b5
);

    import riscv_pkg::*;

    logic [XLEN-1:0] ifid_pc;
    logic [31:0]     ifid_instr;
    logic            ifid_valid;

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            stall;
    logic [XLEN-1:0] rf_rs1_data;
    logic [XLEN-1:0] rf_rs2_data;
    imm_type_e       imm_type;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;

    // Flush beats stall beats load; a flushed slot also clears its PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (PCSrc) begin
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_pc    <= pc_in;
            ifid_instr <= instr_in;
            ifid_valid <= 1'b1;
        end
    end

    always_comb begin
        opcode   = ifid_instr[6:0];
        rd       = ifid_instr[11:7];
        funct3   = ifid_instr[14:12];
        rs1      = ifid_instr[19:15];
        rs2      = ifid_instr[24:20];
        funct7b5 = ifid_instr[30];
    end

    // rs2 is compared regardless of format, so I/U/J-types may stall spuriously.
    always_comb begin
        stall = idex_mem_read && (idex_rd_in != 5'd0) && ifid_valid &&
                ((idex_rd_in == rs1) || (idex_rd_in == rs2));
        PCWrite = ~stall;
    end

    register_file #(
        .XLEN(XLEN)
    ) u_register_file (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rf_rs1_data),
        .rs2_data (rf_rs2_data),
        .we       (reg_write_wb),
        .rd_addr  (rd_wb),
        .wd       (wd_wb)
    );

    always_comb begin
        imm_type = imm_type_of(opcode);
        imm32    = '0;
        case (imm_type)
            IMM_I: imm32 = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
            IMM_S: imm32 = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
            IMM_B: imm32 = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                            ifid_instr[30:25], ifid_instr[11:8], 1'b0};
            IMM_U: imm32 = {ifid_instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                            ifid_instr[20], ifid_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_ext = XLEN'(signed'(imm32));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_rs1_data <= '0;
            id_rs2_data <= '0;
            id_imm      <= '0;
            id_rs1      <= '0;
            id_rs2      <= '0;
            id_rd       <= '0;
            id_opcode   <= '0;
            id_funct3   <= '0;
            id_funct7b5 <= 1'b0;
        end else if (PCSrc || stall) begin
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_rs1_data <= '0;
            id_rs2_data <= '0;
            id_imm      <= '0;
            id_rs1      <= '0;
            id_rs2      <= '0;
            id_rd       <= '0;
            id_opcode   <= '0;
            id_funct3   <= '0;
            id_funct7b5 <= 1'b0;
        end else begin
            id_valid    <= ifid_valid;
            id_pc       <= ifid_pc;
            id_rs1_data <= rf_rs1_data;
            id_rs2_data <= rf_rs2_data;
            id_imm      <= imm_ext;
            id_rs1      <= rs1;
            id_rs2      <= rs2;
            id_rd       <= rd;
            id_opcode   <= opcode;
            id_funct3   <= funct3;
            id_funct7b5 <= funct7b5;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized traffic against a behavioural model.
module tb_decode_stage;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_in;
    logic [31:0]     instr_in;
    logic            PCSrc;
    logic            reg_write_wb;
    logic [4:0]      rd_wb;
    logic [XLEN-1:0] wd_wb;
    logic            idex_mem_read;
    logic [4:0]      idex_rd_in;
    logic            PCWrite;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [6:0]      id_opcode;
    logic [2:0]      id_funct3;
    logic            id_funct7b5;

    always #5 clk = ~clk;

    decode_stage #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_in         (pc_in),
        .instr_in      (instr_in),
        .PCSrc         (PCSrc),
        .reg_write_wb  (reg_write_wb),
        .rd_wb         (rd_wb),
        .wd_wb         (wd_wb),
        .idex_mem_read (idex_mem_read),
        .idex_rd_in    (idex_rd_in),
        .PCWrite       (PCWrite),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_opcode     (id_opcode),
        .id_funct3     (id_funct3),
        .id_funct7b5   (id_funct7b5)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model state: architectural registers, the slot waiting in decode, and what EX should see.
    logic [31:0] m_regs [32];
    logic [31:0] m_if_pc;
    logic [31:0] m_if_instr;
    logic        m_if_valid;
    logic        e_valid;
    logic [31:0] e_pc, e_rs1d, e_rs2d, e_imm;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic        e_f7;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Immediate from the ISA bit layout, built with shifts of the sign-extended word.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic signed [31:0] s;
        logic [31:0] sr20, sr19, sr11;
        s    = ins;
        sr20 = s >>> 20;
        sr19 = s >>> 19;
        sr11 = s >>> 11;
        case (ins[6:0])
            7'b000_0011, 7'b001_0011, 7'b110_0111: return sr20;
            7'b010_0011: return (sr20 & ~32'd31) | (32'(ins[11:7]));
            7'b110_0011: return (sr19 & 32'hFFFF_F000) | (32'(ins[7]) << 11) |
                                (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            7'b011_0111, 7'b001_0111: return ins & 32'hFFFF_F000;
            7'b110_1111: return (sr11 & 32'hFFF0_0000) | (ins & 32'h000F_F000) |
                                (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (BYPASS && reg_write_wb && rd_wb == r) return wd_wb;
        return m_regs[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_if_pc    = 32'd0;
        m_if_instr = NOP;
        m_if_valid = 1'b0;
        e_valid = 1'b0; e_pc = '0; e_rs1d = '0; e_rs2d = '0; e_imm = '0;
        e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_op = '0; e_f3 = '0; e_f7 = 1'b0;
    endtask

    task automatic check_outputs();
        chk("id_valid",    id_valid,    e_valid);
        chk("id_pc",       id_pc,       e_pc);
        chk("id_rs1_data", id_rs1_data, e_rs1d);
        chk("id_rs2_data", id_rs2_data, e_rs2d);
        chk("id_imm",      id_imm,      e_imm);
        chk("id_rs1",      id_rs1,      e_rs1);
        chk("id_rs2",      id_rs2,      e_rs2);
        chk("id_rd",       id_rd,       e_rd);
        chk("id_opcode",   id_opcode,   e_op);
        chk("id_funct3",   id_funct3,   e_f3);
        chk("id_funct7b5", id_funct7b5, e_f7);
    endtask

    // Inputs are already driven; check PCWrite, advance the model one edge, then compare.
    task automatic step();
        logic st;
        #1;
        st = idex_mem_read && (idex_rd_in != 5'd0) && m_if_valid &&
             (idex_rd_in == m_if_instr[19:15] || idex_rd_in == m_if_instr[24:20]);
        chk("pcwrite", PCWrite, !st);
        if (rst) begin
            model_reset();
        end else begin
            if (PCSrc || st) begin
                e_valid = 1'b0; e_pc = '0; e_rs1d = '0; e_rs2d = '0; e_imm = '0;
                e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_op = '0; e_f3 = '0; e_f7 = 1'b0;
            end else begin
                e_valid = m_if_valid;
                e_pc    = m_if_pc;
                e_rs1   = m_if_instr[19:15];
                e_rs2   = m_if_instr[24:20];
                e_rd    = m_if_instr[11:7];
                e_op    = m_if_instr[6:0];
                e_f3    = m_if_instr[14:12];
                e_f7    = m_if_instr[30];
                e_rs1d  = ref_read(e_rs1);
                e_rs2d  = ref_read(e_rs2);
                e_imm   = ref_imm(m_if_instr);
            end
            if (PCSrc) begin
                m_if_pc = 32'd0; m_if_instr = NOP; m_if_valid = 1'b0;
            end else if (!st) begin
                m_if_pc = pc_in; m_if_instr = instr_in; m_if_valid = 1'b1;
            end
            if (reg_write_wb && rd_wb != 5'd0) m_regs[rd_wb] = wd_wb;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        PCSrc = 1'b0; reg_write_wb = 1'b0; rd_wb = '0; wd_wb = '0;
        idex_mem_read = 1'b0; idex_rd_in = '0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'b000_0011;
            1: w[6:0] = 7'b010_0011;
            2: w[6:0] = 7'b110_0011;
            3: w[6:0] = 7'b110_1111;
            4: w[6:0] = 7'b110_0111;
            5: w[6:0] = 7'b011_0111;
            6: w[6:0] = 7'b001_0111;
            7: w[6:0] = 7'b001_0011;
            8: w[6:0] = 7'b011_0011;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        pc_in = '0;
        instr_in = NOP;

        // Pin the model's immediate rules to hand-decoded encodings.
        chk("model_imm_addi", ref_imm(32'h0050_0093), 32'h0000_0005);
        chk("model_imm_beq",  ref_imm(32'hFE00_0EE3), 32'hFFFF_FFFC);
        chk("model_imm_lui",  ref_imm(32'h1234_50B7), 32'h1234_5000);
        chk("model_imm_sw",   ref_imm(32'hFE11_2E23), 32'hFFFF_FFFC);

        #3;
        model_reset();
        check_outputs();
        chk("reset_pcwrite",   PCWrite,        1'b1);
        chk("reset_ifid_inst", dut.ifid_instr, NOP);
        chk("reset_ifid_vld",  dut.ifid_valid, 1'b0);
        step();
        rst = 1'b0;

        // addi x1,x0,5 appears on id_* two edges after presentation
        pc_in = 32'h0; instr_in = 32'h0050_0093; step();
        pc_in = 32'h4; instr_in = NOP; step();
        chk("addi_valid", id_valid, 1'b1);
        chk("addi_rd",    id_rd,    5'd1);
        chk("addi_imm",   id_imm,   32'd5);
        chk("addi_pc",    id_pc,    32'h0);

        // x2 = DEADBEEF, then add x3,x2,x2
        reg_write_wb = 1'b1; rd_wb = 5'd2; wd_wb = 32'hDEAD_BEEF;
        pc_in = 32'h8; instr_in = 32'h0021_01B3; step();
        idle();
        pc_in = 32'hC; instr_in = NOP; step();
        chk("add_rs1_data", id_rs1_data, 32'hDEAD_BEEF);
        chk("add_rs2_data", id_rs2_data, 32'hDEAD_BEEF);

        // same-cycle write of x5=7 while add x6,x5,x0 decodes
        pc_in = 32'h10; instr_in = 32'h0002_8333; step();
        reg_write_wb = 1'b1; rd_wb = 5'd5; wd_wb = 32'd7;
        pc_in = 32'h14; instr_in = NOP; step();
        chk("bypass_x5", id_rs1_data, BYPASS ? 32'd7 : 32'd0);
        idle();

        // load-use: add x6,x4,x1 behind a load into x4
        pc_in = 32'h18; instr_in = 32'h0012_0333; step();
        idex_mem_read = 1'b1; idex_rd_in = 5'd4;
        pc_in = 32'h1C; instr_in = NOP;
        #1;
        chk("loaduse_pcwrite", PCWrite, 1'b0);
        step();
        chk("loaduse_bubble", id_valid, 1'b0);
        chk("loaduse_hold",   dut.ifid_instr, 32'h0012_0333);
        idle();
        #1;
        chk("loaduse_release", PCWrite, 1'b1);
        step();
        chk("loaduse_issue_vld", id_valid, 1'b1);
        chk("loaduse_issue_rs1", id_rs1,   5'd4);
        chk("loaduse_issue_rd",  id_rd,    5'd6);

        // flush together with a stall condition
        pc_in = 32'h20; instr_in = 32'h0012_0333; step();
        PCSrc = 1'b1; idex_mem_read = 1'b1; idex_rd_in = 5'd4;
        #1;
        chk("flush_pcwrite", PCWrite, 1'b0);
        step();
        chk("flush_ifid_instr", dut.ifid_instr, NOP);
        chk("flush_ifid_valid", dut.ifid_valid, 1'b0);
        chk("flush_id_valid",   id_valid,       1'b0);
        idle();

        // negative branch offset, then lui
        pc_in = 32'h24; instr_in = 32'hFE00_0EE3; step();
        pc_in = 32'h28; instr_in = 32'h1234_50B7; step();
        chk("beq_imm", id_imm, 32'hFFFF_FFFC);
        pc_in = 32'h2C; instr_in = NOP; step();
        chk("lui_imm", id_imm, 32'h1234_5000);

        // randomized traffic, with one asynchronous reset mid-stream
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_outputs();
                chk("midreset_pcwrite", PCWrite, 1'b1);
                step();
                rst = 1'b0;
            end
            pc_in        = $urandom & ~32'd3;
            instr_in     = rand_instr();
            PCSrc        = ($urandom_range(0, 9) == 0);
            reg_write_wb = ($urandom_range(0, 1) == 1);
            rd_wb        = ($urandom_range(0, 2) == 0) ? m_if_instr[19:15] : 5'($urandom);
            wd_wb        = $urandom;
            idex_mem_read = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0:       idex_rd_in = m_if_instr[19:15];
                1:       idex_rd_in = m_if_instr[24:20];
                default: idex_rd_in = 5'($urandom);
            endcase
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
